regfile_sweeper: RTL and testbench

- Parametrised register file with a built-in fill engine.
- On `start`, the engine writes every location with a mode-selected data pattern, one location per cycle. It then optionally reads each location back and checks it, and raises `done` (plus `err` on a mismatch).
- External logic can read the file asynchronously at any time.
- Used for table initialisation and as a memory self-test in datapath blocks.

---
 rtl/regfile_sweeper_if.sv | 25 ++
 rtl/regfile_sweeper.sv | 149 ++++++++++++++
 tb/tb_regfile_sweeper.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_sweeper_if.sv
// Bus bundle for regfile_sweeper: fill/verify control, status and the external read port.
interface regfile_sweeper_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] seed;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] err_addr;

  modport master (
    output start, mode, seed, rd_addr,
    input  rd_data, busy, done, err, err_addr
  );

  modport slave (
    input  start, mode, seed, rd_addr,
    output rd_data, busy, done, err, err_addr
  );
endinterface

// File: rtl/regfile_sweeper.sv
// Register file with a pattern fill engine and optional read-back self-test.
// Define REGFILE_SWEEP_VERIFY_EN to include the VERIFY pass; otherwise err/err_addr are tied to 0.
module regfile_sweeper #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  regfile_sweeper_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, FILL, VERIFY, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic [1:0]        mode_r;
  logic [DATA_W-1:0] seed_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] pat_s;
  logic [31:0]       rd_idx_s;

  // Address is zero-extended before the add so mode 1 wraps modulo 2**DATA_W.
  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m,
                                            input logic [DATA_W-1:0] s,
                                            input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] a_ext;
    a_ext = DATA_W'(a);
    case (m)
      2'd0:    pat = s;
      2'd1:    pat = s + a_ext;
      2'd2:    pat = a_ext;
      2'd3:    pat = a[0] ? ~s : s;
      default: pat = s;
    endcase
  endfunction

  assign pat_s = pat(mode_r, seed_r, cnt_r);

`ifdef REGFILE_SWEEP_VERIFY_EN
  logic              err_r;
  logic [ADDR_W-1:0] err_addr_r;
  logic              mismatch_s;

  assign mismatch_s  = (mem_r[cnt_r] != pat_s);
  assign bus.err      = err_r;
  assign bus.err_addr = err_addr_r;
`else
  assign bus.err      = 1'b0;
  assign bus.err_addr = {ADDR_W{1'b0}};
`endif

  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // Control FSM; busy/done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {ADDR_W{1'b0}};
      mode_r     <= 2'd0;
      seed_r     <= {DATA_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef REGFILE_SWEEP_VERIFY_EN
      err_r      <= 1'b0;
      err_addr_r <= {ADDR_W{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            state_r    <= FILL;
            mode_r     <= bus.mode;
            seed_r     <= bus.seed;
            cnt_r      <= {ADDR_W{1'b0}};
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
`ifdef REGFILE_SWEEP_VERIFY_EN
            err_r      <= 1'b0;
            err_addr_r <= {ADDR_W{1'b0}};
`endif
          end
        end
        FILL: begin
          if (cnt_r == LAST_ADDR) begin
            cnt_r   <= {ADDR_W{1'b0}};
`ifdef REGFILE_SWEEP_VERIFY_EN
            state_r <= VERIFY;
`else
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
`endif
          end else begin
            cnt_r <= cnt_r + ADDR_W'(1);
          end
        end
`ifdef REGFILE_SWEEP_VERIFY_EN
        VERIFY: begin
          // Only the first mismatch is recorded.
          if (mismatch_s && !err_r) begin
            err_r      <= 1'b1;
            err_addr_r <= cnt_r;
          end
          if (cnt_r == LAST_ADDR) begin
            cnt_r   <= {ADDR_W{1'b0}};
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + ADDR_W'(1);
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          cnt_r   <= {ADDR_W{1'b0}};
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; only the fill engine writes it.
  always_ff @(posedge clk) begin
    if (!rst && state_r == FILL) begin
      mem_r[cnt_r] <= pat_s;
    end
  end

  assign rd_idx_s = 32'(bus.rd_addr);

  // External read port returns 0 for addresses past the last word.
  always_comb begin
    bus.rd_data = {DATA_W{1'b0}};
    if (rd_idx_s < 32'(DEPTH)) begin
      bus.rd_data = mem_r[bus.rd_addr];
    end else begin
      bus.rd_data = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_regfile_sweeper.sv
// Directed self-checking bench for regfile_sweeper (DEPTH=16, DATA_W=32).
module tb_regfile_sweeper;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef REGFILE_SWEEP_VERIFY_EN
  localparam int LAT = 2 * DEPTH;
`else
  localparam int LAT = DEPTH;
`endif

  logic clk;
  logic rst;
  int   total_cnt;
  int   pass_cnt;
  int   fail_cnt;
  int   n;

  regfile_sweeper_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_sweeper #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start; returns #1 after the accepting edge.
  task automatic pulse_start(input logic [1:0] m, input logic [31:0] s);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.seed  = s;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts edges until done, continuing from n0, bounded.
  task automatic wait_done(input int n0, output int nout);
    int k;
    k = n0;
    while (bus.done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    nout = k;
  endtask

  task automatic read_at(input int a, output logic [31:0] d);
    bus.rd_addr = 4'(a);
    #1;
    d = bus.rd_data;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp;
    total_cnt = 0;
    pass_cnt  = 0;
    fail_cnt  = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.mode   = 2'd0;
    bus.seed   = 32'h0;
    bus.rd_addr = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_err_addr", 32'(bus.err_addr), 32'd0);

    // Mode 0: constant seed everywhere.
    pulse_start(2'd0, 32'hA5A5A5A5);
    check("m0_busy", 32'(bus.busy), 32'd1);
    wait_done(0, n);
    check("m0_latency", 32'(n), 32'(LAT));
    check("m0_busy_off", 32'(bus.busy), 32'd0);
    check("m0_err", 32'(bus.err), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      read_at(a, d);
      check("m0_data", d, 32'hA5A5A5A5);
    end

    // Mode 1: seed + address with wrap.
    pulse_start(2'd1, 32'hFFFFFFFE);
    check("m1_done_drop", 32'(bus.done), 32'd0);
    wait_done(0, n);
    check("m1_latency", 32'(n), 32'(LAT));
    read_at(0, d);  check("m1_a0", d, 32'hFFFFFFFE);
    read_at(1, d);  check("m1_a1", d, 32'hFFFFFFFF);
    read_at(2, d);  check("m1_a2", d, 32'h00000000);
    read_at(15, d); check("m1_a15", d, 32'h0000000D);
    check("m1_err", 32'(bus.err), 32'd0);

    // Mode 3: checkerboard of seed 0.
    pulse_start(2'd3, 32'h0);
    wait_done(0, n);
    check("m3_latency", 32'(n), 32'(LAT));
    for (int a = 0; a < DEPTH; a++) begin
      read_at(a, d);
      exp = (a % 2 == 1) ? 32'hFFFFFFFF : 32'h0;
      check("m3_data", d, exp);
    end

`ifdef REGFILE_SWEEP_VERIFY_EN
    // Corrupt words 5 and 9 after the first verify compare, before address 5 is reached.
    pulse_start(2'd0, 32'h12345678);
    repeat (DEPTH + 1) tick();
    check("inj_busy", 32'(bus.busy), 32'd1);
    dut.mem_r[5] = 32'hDEAD0005;
    dut.mem_r[9] = 32'hDEAD0009;
    wait_done(DEPTH + 1, n);
    check("inj_latency", 32'(n), 32'(LAT));
    check("inj_done", 32'(bus.done), 32'd1);
    check("inj_err", 32'(bus.err), 32'd1);
    check("inj_err_addr", 32'(bus.err_addr), 32'd5);
`endif

    // Reset at FILL cycle 7, then a full mode-2 re-fill.
    pulse_start(2'd1, 32'hCAFE0000);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    pulse_start(2'd2, 32'h55555555);
    wait_done(0, n);
    check("m2_latency", 32'(n), 32'(LAT));
    check("m2_err", 32'(bus.err), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      read_at(a, d);
      check("m2_data", d, 32'(a));
    end

    // A start pulse while busy must neither restart nor change contents.
    pulse_start(2'd0, 32'h00000007);
    repeat (3) tick();
    bus.start = 1'b1;
    bus.mode  = 2'd2;
    bus.seed  = 32'h00000099;
    tick();
    bus.start = 1'b0;
    wait_done(4, n);
    check("busy_start_latency", 32'(n), 32'(LAT));
    read_at(0, d);  check("busy_start_a0", d, 32'h00000007);
    read_at(13, d); check("busy_start_a13", d, 32'h00000007);
    repeat (3) tick();
    check("done_held", 32'(bus.done), 32'd1);

    // Restart from DONE with seed 1.
    pulse_start(2'd0, 32'h00000001);
    check("restart_done_drop", 32'(bus.done), 32'd0);
    check("restart_busy", 32'(bus.busy), 32'd1);
    wait_done(0, n);
    check("restart_latency", 32'(n), 32'(LAT));
    for (int a = 0; a < DEPTH; a++) begin
      read_at(a, d);
      check("restart_data", d, 32'h00000001);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
